// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared definitions for the multi-cycle RV32I control unit.
//   - base opcode constants (inst[6:0])
//   - FSM state encoding (3 bits, mirrored on mcycle_ctrl.state_o)
//   - immediate-select encoding driven to the immediate generator
//   - instruction class produced by ctrl_decode
package rv32i_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_WAIT_I = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd6
  } state_e;

  typedef enum logic [2:0] {
    IMM_I   = 3'd0,
    IMM_S   = 3'd1,
    IMM_SB  = 3'd2,
    IMM_U   = 3'd3,
    IMM_UJ  = 3'd4,
    IMM_CSR = 3'd5
  } imm_sel_e;

  typedef enum logic [2:0] {
    CL_ALU     = 3'd0,
    CL_LOAD    = 3'd1,
    CL_STORE   = 3'd2,
    CL_BRANCH  = 3'd3,
    CL_JUMP    = 3'd4,
    CL_CSR     = 3'd5,
    CL_ILLEGAL = 3'd6
  } iclass_e;

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational opcode decoder for mcycle_ctrl.
// Build option: RV32I_CSR_EN -- when defined, SYSTEM with funct3!=0 decodes
// as a CSR access; otherwise every SYSTEM opcode is illegal.
// Ports:
//   opcode  in  7  inst[6:0]
//   funct3  in  3  inst[14:12]
//   iclass  out    instruction class steering the FSM
//   imm_sel out    immediate format for the immediate generator
module ctrl_decode
  import rv32i_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  output iclass_e    iclass,
  output imm_sel_e   imm_sel
);

`ifndef RV32I_CSR_EN
  logic funct3_unused;
  assign funct3_unused = ^funct3;
`endif

  always_comb begin
    iclass  = CL_ILLEGAL;
    imm_sel = IMM_I;
    // Compressed encodings (inst[1:0] != 2'b11) are not supported.
    if (opcode[1:0] == 2'b11) begin
      case (opcode)
        OPC_LOAD:   begin iclass = CL_LOAD;   imm_sel = IMM_I;  end
        OPC_STORE:  begin iclass = CL_STORE;  imm_sel = IMM_S;  end
        OPC_BRANCH: begin iclass = CL_BRANCH; imm_sel = IMM_SB; end
        OPC_OP_IMM: begin iclass = CL_ALU;    imm_sel = IMM_I;  end
        OPC_OP:     begin iclass = CL_ALU;    imm_sel = IMM_I;  end
        OPC_LUI,
        OPC_AUIPC:  begin iclass = CL_ALU;    imm_sel = IMM_U;  end
        OPC_JAL:    begin iclass = CL_JUMP;   imm_sel = IMM_UJ; end
        OPC_JALR:   begin iclass = CL_JUMP;   imm_sel = IMM_I;  end
`ifdef RV32I_CSR_EN
        OPC_SYSTEM: begin
          if (funct3 != 3'b000) begin
            iclass  = CL_CSR;
            imm_sel = IMM_CSR;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mcycle_ctrl.sv
// mcycle_ctrl: multi-cycle RV32I control FSM with PC register and
// instruction latch. Build option RV32I_CSR_EN (see ctrl_decode).
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   imem_req/imem_addr             fetch request, address = pc_o
//   imem_valid/imem_rdata          fetch response
//   dmem_req/dmem_we/dmem_ready    data access handshake
//   inst_o                         latched instruction
//   imm_sel                        immediate select (holds outside DECODE..WB)
//   br_taken, tgt_i                branch outcome / jump-branch target
//   pc_o, rf_we, trap, state_o     PC, register write pulse, trap flag, state
//
// state   | meaning
// FETCH   | issue imem request for pc_o, arm wait timer
// WAIT_I  | hold request until imem_valid, latch instruction
// DECODE  | classify opcode, drive imm_sel; illegal -> TRAP
// EXEC    | route to MEM / WB, or resolve branch and refetch
// MEM     | hold dmem request until dmem_ready
// WB      | one-cycle register-file write, then refetch
// TRAP    | sticky fault; only rst leaves
module mcycle_ctrl
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ready,
  output logic [31:0] inst_o,
  output logic [2:0]  imm_sel,
  input  logic        br_taken,
  input  logic [31:0] tgt_i,
  output logic [31:0] pc_o,
  output logic        rf_we,
  output logic        trap,
  output logic [2:0]  state_o
);

  localparam int unsigned WW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

  state_e         state, state_n;
  iclass_e        dec_class;
  imm_sel_e       dec_imm, imm_q;
  logic [WW-1:0]  wait_cnt;
  logic [31:0]    new_pc;
  logic           take_tgt, leave, pc_load;

  ctrl_decode u_decode (
    .opcode  (inst_o[6:0]),
    .funct3  (inst_o[14:12]),
    .iclass  (dec_class),
    .imm_sel (dec_imm)
  );

  assign take_tgt  = (dec_class == CL_JUMP) || ((dec_class == CL_BRANCH) && br_taken);
  assign new_pc    = take_tgt ? tgt_i : (pc_o + 32'd4);
  assign imem_addr = pc_o;
  assign state_o   = state;
  // Show the fresh decode in DECODE itself; the register keeps it afterwards.
  assign imm_sel   = ((state == ST_DECODE) && (dec_class != CL_ILLEGAL)) ? dec_imm : imm_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_FETCH;
      pc_o     <= RESET_PC;
      inst_o   <= INST_NOP;
      imm_q    <= IMM_I;
      wait_cnt <= '0;
    end else begin
      state <= state_n;
      if ((state == ST_WAIT_I) && imem_valid)
        inst_o <= imem_rdata;
      if (pc_load)
        pc_o <= new_pc;
      if ((state == ST_DECODE) && (dec_class != CL_ILLEGAL))
        imm_q <= dec_imm;
      // Down-counter armed on entry to each handshake state; zero is terminal.
      if ((state == ST_FETCH) || (state == ST_EXEC))
        wait_cnt <= WW'(MAX_WAIT - 1);
      else if (((state == ST_WAIT_I) || (state == ST_MEM)) && (wait_cnt != '0))
        wait_cnt <= wait_cnt - 1'b1;
    end
  end

  always_comb begin
    state_n  = state;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    rf_we    = 1'b0;
    trap     = 1'b0;
    leave    = 1'b0;
    pc_load  = 1'b0;
    case (state)
      ST_FETCH: begin
        imem_req = 1'b1;
        state_n  = ST_WAIT_I;
      end
      ST_WAIT_I: begin
        imem_req = 1'b1;
        if (imem_valid)
          state_n = ST_DECODE;
        else if (wait_cnt == '0)
          state_n = ST_TRAP;
      end
      ST_DECODE: begin
        state_n = (dec_class == CL_ILLEGAL) ? ST_TRAP : ST_EXEC;
      end
      ST_EXEC: begin
        if ((dec_class == CL_LOAD) || (dec_class == CL_STORE))
          state_n = ST_MEM;
        else if (dec_class == CL_BRANCH)
          leave = 1'b1;
        else
          state_n = ST_WB;
      end
      ST_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (dec_class == CL_STORE);
        if (dmem_ready) begin
          if (dec_class == CL_LOAD)
            state_n = ST_WB;
          else
            leave = 1'b1;
        end else if (wait_cnt == '0) begin
          state_n = ST_TRAP;
        end
      end
      ST_WB: begin
        rf_we = 1'b1;
        leave = 1'b1;
      end
      ST_TRAP: begin
        trap = 1'b1;
      end
      default: state_n = ST_TRAP;
    endcase
    // A misaligned next PC is a fault: trap and keep the old PC.
    if (leave) begin
      if (new_pc[1:0] != 2'b00) begin
        state_n = ST_TRAP;
      end else begin
        state_n = ST_FETCH;
        pc_load = 1'b1;
      end
    end
  end

endmodule
